// File: rtl/fe_capture_multi.sv
// fe_capture_multi: multi-channel front-end event capture. Events are held as
// per-channel pending flags and drained round-robin into DATA records. Each
// record carries the time since the previous record. TIME records are
// inserted when that delta is too large for a short DATA record, or when the
// delta counter is about to saturate.
// Optional feature: define FE_CAPTURE_MULTI_STATS_EN to add O_dropped_events.
module fe_capture_multi #(
    parameter int pCHANNELS             = 4,
    parameter int pTIMESTAMP_FULL_WIDTH = 16,
    parameter int pCAPTURE_LEN_WIDTH    = 24,
    localparam int CW = (pCHANNELS > 1) ? $clog2(pCHANNELS) : 1
) (
    input  logic                             fe_clk,
    input  logic                             reset_n,
    input  logic [pCHANNELS-1:0]             I_event,
    input  logic [2*pCHANNELS-1:0]           I_data_cmd,
    input  logic                             I_arm,
    input  logic                             I_capture_enable,
    input  logic                             I_target_trig,
    input  logic                             I_capture_while_trig,
    input  logic [pCAPTURE_LEN_WIDTH-1:0]    I_capture_len,
    input  logic [pTIMESTAMP_FULL_WIDTH-1:0] I_max_short_timestamp,
    input  logic                             I_fifo_full,
    output logic                             O_fifo_wr,
    output logic [1:0]                       O_fifo_command,
    output logic [CW-1:0]                    O_fifo_chan,
    output logic [pTIMESTAMP_FULL_WIDTH-1:0] O_fifo_time,
    output logic                             O_capturing,
    output logic                             O_capture_done,
`ifdef FE_CAPTURE_MULTI_STATS_EN
    output logic [15:0]                      O_dropped_events,
`endif
    output logic                             O_overflow
);
    localparam int TW = pTIMESTAMP_FULL_WIDTH;
    localparam int LW = pCAPTURE_LEN_WIDTH;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARMED   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam logic [1:0]    FE_FIFO_CMD_TIME = 2'b11;
    localparam logic [TW-1:0] DELTA_MAX        = '1;
    localparam logic [TW-1:0] DELTA_SAT        = DELTA_MAX - TW'(1);

    logic [1:0]             state;
    logic [pCHANNELS-1:0]   ev_q;
    logic [2*pCHANNELS-1:0] cmd_q;
    logic [pCHANNELS-1:0]   pending;
    logic [2*pCHANNELS-1:0] cmd_lat;
    logic [CW-1:0]          rr_ptr;
    logic [TW-1:0]          delta;
    logic [LW-1:0]          cap_cnt;

    logic                   cap, stop, issue_ok;
    logic                   found, is_short, do_data, do_time, do_wr;
    logic [CW-1:0]          sel, cand;
    logic [1:0]             sel_cmd;
    logic [pCHANNELS-1:0]   clr_mask, set_mask, drop_mask;

    assign O_capturing    = (state == CAPTURE);
    assign O_capture_done = (state == DONE);

    // Stop conditions and write qualification for the current CAPTURE cycle
    always_comb begin
        cap      = (state == CAPTURE);
        stop     = cap && (I_fifo_full || !I_capture_enable ||
                           (I_capture_while_trig && !I_target_trig) ||
                           ((I_capture_len != '0) && (cap_cnt >= I_capture_len)));
        issue_ok = cap && !stop;
    end

    // Round-robin search for the first pending channel starting at rr_ptr
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < pCHANNELS; i++) begin
            cand = CW'((32'(rr_ptr) + i) % pCHANNELS);
            if (!found && pending[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // Record selection and pending-flag set/clear/drop masks
    always_comb begin
        sel_cmd  = cmd_lat[2*sel +: 2];
        is_short = (delta <= I_max_short_timestamp);
        do_data  = issue_ok && found && is_short;
        do_time  = issue_ok && ((found && !is_short) || (!found && (delta == DELTA_SAT)));
        do_wr    = do_data || do_time;
        clr_mask = '0;
        if (do_data) begin
            clr_mask[sel] = 1'b1;
        end
        // A flag cleared by this cycle's grant may accept a new event at once
        set_mask  = ev_q & (~pending | clr_mask);
        drop_mask = ev_q & pending & ~clr_mask;
    end

    // Capture state machine and sticky overflow flag
    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            O_overflow <= 1'b0;
        end else if (I_arm) begin
            state      <= ARMED;
            O_overflow <= 1'b0;
        end else begin
            case (state)
                ARMED: begin
                    if (I_capture_enable && (I_capture_while_trig ? I_target_trig : 1'b1)) begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (stop) begin
                        state <= DONE;
                    end
                    if (I_fifo_full) begin
                        O_overflow <= 1'b1;
                    end
                end
                default: state <= state;
            endcase
        end
    end

    // Delta-time counter and DATA-record counter
    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            delta   <= '0;
            cap_cnt <= '0;
        end else if (I_arm) begin
            delta   <= '0;
            cap_cnt <= '0;
        end else begin
            if (!issue_ok) begin
                delta <= '0;
            end else if (do_wr) begin
                delta <= TW'(1);
            end else if (delta != DELTA_MAX) begin
                delta <= delta + TW'(1);
            end
            if (do_data && (cap_cnt != '1)) begin
                cap_cnt <= cap_cnt + LW'(1);
            end
        end
    end

    // Event input stage, pending flags with latched commands, round-robin pointer
    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            ev_q    <= '0;
            cmd_q   <= '0;
            pending <= '0;
            cmd_lat <= '0;
            rr_ptr  <= '0;
        end else if (I_arm) begin
            ev_q    <= '0;
            pending <= '0;
            rr_ptr  <= '0;
        end else begin
            ev_q  <= cap ? I_event : '0;
            cmd_q <= I_data_cmd;
            if (cap) begin
                pending <= (pending & ~clr_mask) | set_mask;
                for (int unsigned c = 0; c < pCHANNELS; c++) begin
                    if (set_mask[c]) begin
                        cmd_lat[2*c +: 2] <= cmd_q[2*c +: 2];
                    end
                end
            end
            if (do_data) begin
                rr_ptr <= (sel == CW'(pCHANNELS - 1)) ? '0 : sel + CW'(1);
            end
        end
    end

    // Registered FIFO write port
    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            O_fifo_wr      <= 1'b0;
            O_fifo_command <= '0;
            O_fifo_chan    <= '0;
            O_fifo_time    <= '0;
        end else if (I_arm) begin
            O_fifo_wr <= 1'b0;
        end else begin
            O_fifo_wr <= do_wr;
            if (do_wr) begin
                O_fifo_command <= do_data ? sel_cmd : FE_FIFO_CMD_TIME;
                O_fifo_chan    <= do_data ? sel : '0;
                O_fifo_time    <= delta;
            end
        end
    end

`ifdef FE_CAPTURE_MULTI_STATS_EN
    logic [16:0] drop_sum;
    assign drop_sum = {1'b0, O_dropped_events} + 17'($countones(drop_mask));

    // Saturating count of events lost to an already-pending channel
    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            O_dropped_events <= '0;
        end else if (I_arm) begin
            O_dropped_events <= '0;
        end else if (cap) begin
            O_dropped_events <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_fe_capture_multi.sv
// tb_fe_capture_multi: directed and randomized checks of fe_capture_multi
// against a cycle-level behavioural model kept in this file.
module tb_fe_capture_multi;
    localparam int N  = 4;
    localparam int TW = 16;
    localparam int LW = 24;
    localparam int CW = 2;

    logic            fe_clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    I_event;
    logic [2*N-1:0]  I_data_cmd;
    logic            I_arm, I_capture_enable, I_target_trig, I_capture_while_trig;
    logic [LW-1:0]   I_capture_len;
    logic [TW-1:0]   I_max_short_timestamp;
    logic            I_fifo_full;
    logic            O_fifo_wr;
    logic [1:0]      O_fifo_command;
    logic [CW-1:0]   O_fifo_chan;
    logic [TW-1:0]   O_fifo_time;
    logic            O_capturing, O_capture_done, O_overflow;
`ifdef FE_CAPTURE_MULTI_STATS_EN
    logic [15:0]     O_dropped_events;
`endif

    int vectors = 0;
    int fails   = 0;

    always #5 fe_clk = ~fe_clk;

    fe_capture_multi #(
        .pCHANNELS(N),
        .pTIMESTAMP_FULL_WIDTH(TW),
        .pCAPTURE_LEN_WIDTH(LW)
    ) dut (
        .fe_clk(fe_clk),
        .reset_n(reset_n),
        .I_event(I_event),
        .I_data_cmd(I_data_cmd),
        .I_arm(I_arm),
        .I_capture_enable(I_capture_enable),
        .I_target_trig(I_target_trig),
        .I_capture_while_trig(I_capture_while_trig),
        .I_capture_len(I_capture_len),
        .I_max_short_timestamp(I_max_short_timestamp),
        .I_fifo_full(I_fifo_full),
        .O_fifo_wr(O_fifo_wr),
        .O_fifo_command(O_fifo_command),
        .O_fifo_chan(O_fifo_chan),
        .O_fifo_time(O_fifo_time),
        .O_capturing(O_capturing),
        .O_capture_done(O_capture_done),
`ifdef FE_CAPTURE_MULTI_STATS_EN
        .O_dropped_events(O_dropped_events),
`endif
        .O_overflow(O_overflow)
    );

    // ---------------- behavioural reference model ----------------
    typedef enum {M_IDLE, M_ARMED, M_CAP, M_DONE} mstate_t;
    mstate_t ms;
    int  m_delta, m_count, m_rr, m_drop;
    bit  m_ovf, m_wr;
    int  m_ocmd, m_ochan, m_otime;
    bit  m_pend[N];
    int  m_cmd[N];
    bit  m_stage[N];
    int  m_stage_cmd[N];

    function automatic void model_reset();
        ms = M_IDLE; m_delta = 0; m_count = 0; m_rr = 0; m_drop = 0;
        m_ovf = 0; m_wr = 0; m_ocmd = 0; m_ochan = 0; m_otime = 0;
        for (int c = 0; c < N; c++) begin
            m_pend[c] = 0; m_cmd[c] = 0; m_stage[c] = 0; m_stage_cmd[c] = 0;
        end
    endfunction

    function automatic void model_step();
        bit cap, stop, found;
        int ch;
        cap = (ms == M_CAP);
        if (I_arm) begin
            ms = M_ARMED; m_delta = 0; m_count = 0; m_rr = 0; m_drop = 0;
            m_ovf = 0; m_wr = 0;
            for (int c = 0; c < N; c++) begin
                m_pend[c] = 0; m_stage[c] = 0;
            end
            return;
        end
        stop = cap && (I_fifo_full || !I_capture_enable ||
                       (I_capture_while_trig && !I_target_trig) ||
                       (I_capture_len != 0 && m_count >= int'(I_capture_len)));
        m_wr = 0; found = 0; ch = 0;
        if (cap && !stop) begin
            for (int i = 0; i < N; i++) begin
                if (!found && m_pend[(m_rr + i) % N]) begin
                    found = 1; ch = (m_rr + i) % N;
                end
            end
            if (found && m_delta <= int'(I_max_short_timestamp)) begin
                m_wr = 1; m_ocmd = m_cmd[ch]; m_ochan = ch; m_otime = m_delta;
                m_pend[ch] = 0; m_rr = (ch + 1) % N; m_count++;
            end else if (found || m_delta == (1 << TW) - 2) begin
                m_wr = 1; m_ocmd = 3; m_ochan = 0; m_otime = m_delta;
            end
        end
        if (cap) begin
            for (int c = 0; c < N; c++) begin
                if (m_stage[c]) begin
                    if (m_pend[c]) begin
                        if (m_drop < 65535) m_drop++;
                    end else begin
                        m_pend[c] = 1; m_cmd[c] = m_stage_cmd[c];
                    end
                end
            end
        end
        for (int c = 0; c < N; c++) begin
            m_stage[c]     = cap && I_event[c];
            m_stage_cmd[c] = int'(I_data_cmd[2*c +: 2]);
        end
        if (cap && !stop) m_delta = m_wr ? 1 : ((m_delta < (1 << TW) - 1) ? m_delta + 1 : m_delta);
        else              m_delta = 0;
        if (ms == M_ARMED && I_capture_enable && (!I_capture_while_trig || I_target_trig)) begin
            ms = M_CAP;
        end else if (ms == M_CAP && stop) begin
            ms = M_DONE;
            if (I_fifo_full) m_ovf = 1;
        end
    endfunction

    always @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_step();
    end

    function automatic logic [23:0] obs_vec();
        return {O_fifo_wr, O_fifo_wr ? {O_fifo_command, O_fifo_chan, O_fifo_time} : 20'h0,
                O_capturing, O_capture_done, O_overflow};
    endfunction

    function automatic logic [23:0] exp_vec();
        return {m_wr, m_wr ? {2'(m_ocmd), 2'(m_ochan), 16'(m_otime)} : 20'h0,
                ms == M_CAP, ms == M_DONE, m_ovf};
    endfunction

    typedef struct packed {
        logic [1:0]  cmd;
        logic [1:0]  chan;
        logic [15:0] t;
        int          cyc;
    } rec_t;

    // ---------------- stimulus helpers ----------------
    task automatic clk1();
        @(posedge fe_clk);
        #1;
    endtask

    task automatic idle_inputs();
        I_event = '0; I_data_cmd = '0; I_arm = 0; I_capture_enable = 0;
        I_target_trig = 0; I_capture_while_trig = 0; I_capture_len = '0;
        I_max_short_timestamp = 16'd8; I_fifo_full = 0;
    endtask

    task automatic arm_and_enable();
        I_arm = 1; I_capture_enable = 1;
        clk1();
        I_arm = 0;
        clk1();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b1;
        idle_inputs();
        model_reset();
        #2 reset_n = 1'b0;
        repeat (3) clk1();
        if (obs_vec() !== 24'h0) begin
            fails++; $display("FAIL reset_state got=%h exp=%h", obs_vec(), 24'h0);
        end
        vectors++;
        reset_n = 1'b1;
        I_capture_enable = 1; I_event = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            clk1();
            if (obs_vec() !== exp_vec()) begin
                fails++; $display("FAIL reset_release cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            vectors++;
        end
        if (O_capturing !== 1'b0) begin
            fails++; $display("FAIL reset_needs_arm got=%b exp=0", O_capturing);
        end
        vectors++;
    endtask

    task automatic test_two_events();
        rec_t q[$];
        rec_t r;
        idle_inputs();
        arm_and_enable();
        I_event = 4'b0101; I_data_cmd = 8'b0010_0001;
        for (int c = 0; c < 8; c++) begin
            clk1();
            I_event = '0;
            if (obs_vec() !== exp_vec()) begin
                fails++; $display("FAIL two_events cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            vectors++;
            if (O_fifo_wr === 1'b1) begin
                r.cmd = O_fifo_command; r.chan = O_fifo_chan; r.t = O_fifo_time; r.cyc = c;
                q.push_back(r);
            end
        end
        if (q.size() != 2) begin
            fails++; $display("FAIL two_events_count got=%0d exp=2", q.size());
        end
        vectors++;
        if (q.size() == 2) begin
            if ({q[0].cmd, q[0].chan, q[0].t} !== {2'b01, 2'd0, 16'd2}) begin
                fails++; $display("FAIL two_events_first got=%h exp=%h", {q[0].cmd, q[0].chan, q[0].t}, {2'b01, 2'd0, 16'd2});
            end
            vectors++;
            if ({q[1].cmd, q[1].chan, q[1].t} !== {2'b10, 2'd2, 16'd1} || q[1].cyc != q[0].cyc + 1) begin
                fails++; $display("FAIL two_events_second got=%h cyc=%0d exp=%h cyc=%0d",
                                  {q[1].cmd, q[1].chan, q[1].t}, q[1].cyc, {2'b10, 2'd2, 16'd1}, q[0].cyc + 1);
            end
            vectors++;
        end
    endtask

    task automatic test_time_record();
        rec_t q[$];
        rec_t r;
        idle_inputs();
        arm_and_enable();
        for (int c = 0; c < 19; c++) begin
            clk1();
            if (obs_vec() !== exp_vec()) begin
                fails++; $display("FAIL time_idle cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            vectors++;
        end
        I_event = 4'b0010; I_data_cmd = 8'b0000_0100;
        for (int c = 0; c < 6; c++) begin
            clk1();
            I_event = '0;
            if (obs_vec() !== exp_vec()) begin
                fails++; $display("FAIL time_record cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            vectors++;
            if (O_fifo_wr === 1'b1) begin
                r.cmd = O_fifo_command; r.chan = O_fifo_chan; r.t = O_fifo_time; r.cyc = c;
                q.push_back(r);
            end
        end
        if (q.size() != 2 || {q[0].cmd, q[0].chan, q[0].t} !== {2'b11, 2'd0, 16'd21}) begin
            fails++; $display("FAIL time_record_time n=%0d got=%h exp=%h", q.size(), {q[0].cmd, q[0].chan, q[0].t}, {2'b11, 2'd0, 16'd21});
        end
        vectors++;
        if (q.size() == 2) begin
            if ({q[1].cmd, q[1].chan, q[1].t} !== {2'b01, 2'd1, 16'd1} || q[1].cyc != q[0].cyc + 1) begin
                fails++; $display("FAIL time_record_data got=%h exp=%h", {q[1].cmd, q[1].chan, q[1].t}, {2'b01, 2'd1, 16'd1});
            end
            vectors++;
        end
    endtask

    task automatic test_capture_len();
        int ndata = 0;
        idle_inputs();
        I_max_short_timestamp = 16'hFFFF; I_capture_len = 24'd3;
        arm_and_enable();
        I_event = 4'b1000; I_data_cmd = 8'b1000_0000;
        for (int c = 0; c < 20; c++) begin
            clk1();
            if (obs_vec() !== exp_vec()) begin
                fails++; $display("FAIL capture_len cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            vectors++;
            if (O_fifo_wr === 1'b1 && O_fifo_command === 2'b10 && O_fifo_chan === 2'd3) ndata++;
        end
        if (ndata != 3 || O_capture_done !== 1'b1) begin
            fails++; $display("FAIL capture_len_total got=%0d done=%b exp=3 done=1", ndata, O_capture_done);
        end
        vectors++;
    endtask

    task automatic test_fifo_full();
        int nw = 0;
        idle_inputs();
        arm_and_enable();
        for (int c = 0; c < 15; c++) begin
            I_event = 4'($urandom); I_data_cmd = 8'($urandom);
            clk1();
            if (obs_vec() !== exp_vec()) begin
                fails++; $display("FAIL fifo_pre cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            vectors++;
        end
        I_fifo_full = 1;
        for (int c = 0; c < 8; c++) begin
            I_event = 4'($urandom);
            clk1();
            if (obs_vec() !== exp_vec()) begin
                fails++; $display("FAIL fifo_full cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            vectors++;
            if (O_fifo_wr !== 1'b0) nw++;
        end
        if (nw != 0 || O_overflow !== 1'b1 || O_capture_done !== 1'b1) begin
            fails++; $display("FAIL fifo_full_stop writes=%0d ovf=%b done=%b exp writes=0 ovf=1 done=1", nw, O_overflow, O_capture_done);
        end
        vectors++;
        I_fifo_full = 0;
    endtask

    task automatic test_dropped();
        logic [3:0] sched [10] = '{4'b0001, 4'b0000, 4'b0000, 4'b0011, 4'b0001,
                                   4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        idle_inputs();
        I_max_short_timestamp = 16'hFFFF;
        arm_and_enable();
        for (int c = 0; c < 10; c++) begin
            I_event = sched[c]; I_data_cmd = 8'($urandom);
            clk1();
            if (obs_vec() !== exp_vec()) begin
                fails++; $display("FAIL dropped_seq cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            vectors++;
        end
`ifdef FE_CAPTURE_MULTI_STATS_EN
        if (O_dropped_events !== 16'd1) begin
            fails++; $display("FAIL dropped_count got=%0d exp=1", O_dropped_events);
        end
        vectors++;
`endif
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            idle_inputs();
            I_max_short_timestamp = 16'($urandom_range(0, 5));
            I_capture_len = 24'($urandom_range(0, 6));
            I_capture_while_trig = 1'($urandom_range(0, 1));
            I_target_trig = 1;
            arm_and_enable();
            for (int c = 0; c < 60; c++) begin
                I_event = 4'($urandom) & 4'($urandom);
                I_data_cmd = 8'($urandom);
                I_target_trig = ($urandom_range(0, 39) != 0);
                I_fifo_full = ($urandom_range(0, 79) == 0);
                I_capture_enable = ($urandom_range(0, 69) != 0);
                I_arm = ($urandom_range(0, 99) == 0);
                clk1();
                if (obs_vec() !== exp_vec()) begin
                    fails++; $display("FAIL random r=%0d cyc=%0d got=%h exp=%h", r, c, obs_vec(), exp_vec());
                end
                vectors++;
`ifdef FE_CAPTURE_MULTI_STATS_EN
                if (O_dropped_events !== 16'(m_drop)) begin
                    fails++; $display("FAIL random_drops r=%0d cyc=%0d got=%0d exp=%0d", r, c, O_dropped_events, m_drop);
                end
                vectors++;
`endif
            end
        end
        idle_inputs();
    endtask

    task automatic test_saturation();
        int hit = -1;
        int t_after = -1;
        idle_inputs();
        arm_and_enable();
        for (int c = 0; c < 70000 && hit < 0; c++) begin
            clk1();
            if (obs_vec() !== exp_vec()) begin
                fails++; $display("FAIL saturation cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            vectors++;
            if (O_fifo_wr === 1'b1) begin
                hit = c;
                if ({O_fifo_command, O_fifo_chan, O_fifo_time} !== {2'b11, 2'd0, 16'hFFFE}) begin
                    fails++; $display("FAIL saturation_record got=%h exp=%h", {O_fifo_command, O_fifo_chan, O_fifo_time}, {2'b11, 2'd0, 16'hFFFE});
                end
                vectors++;
            end
        end
        if (hit != 65534) begin
            fails++; $display("FAIL saturation_cycle got=%0d exp=65534", hit);
        end
        vectors++;
        I_event = 4'b0001; I_data_cmd = '0;
        for (int c = 0; c < 6; c++) begin
            clk1();
            I_event = '0;
            if (obs_vec() !== exp_vec()) begin
                fails++; $display("FAIL saturation_after cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            vectors++;
            if (O_fifo_wr === 1'b1 && t_after < 0) t_after = int'(O_fifo_time);
        end
        if (t_after != 3) begin
            fails++; $display("FAIL saturation_restart got=%0d exp=3", t_after);
        end
        vectors++;
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        I_max_short_timestamp = 16'hFFFF;
        arm_and_enable();
        I_event = 4'b1111; I_data_cmd = 8'hE4;
        for (int c = 0; c < 6; c++) begin
            clk1();
            if (obs_vec() !== exp_vec()) begin
                fails++; $display("FAIL reset_mid_pre cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            vectors++;
        end
        if (O_capturing !== 1'b1) begin
            fails++; $display("FAIL reset_mid_capturing got=%b exp=1", O_capturing);
        end
        vectors++;
        #2 reset_n = 1'b0;
        #1;
        if (obs_vec() !== 24'h0) begin
            fails++; $display("FAIL reset_mid_async got=%h exp=%h", obs_vec(), 24'h0);
        end
        vectors++;
        clk1();
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            clk1();
            if (obs_vec() !== exp_vec()) begin
                fails++; $display("FAIL reset_mid_post cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            vectors++;
        end
        if (O_capturing !== 1'b0 || O_fifo_wr !== 1'b0) begin
            fails++; $display("FAIL reset_mid_idle got cap=%b wr=%b exp cap=0 wr=0", O_capturing, O_fifo_wr);
        end
        vectors++;
    endtask

    initial begin
        test_reset();
        test_two_events();
        test_time_record();
        test_capture_len();
        test_fifo_full();
        test_dropped();
        test_random();
        test_saturation();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired vectors=%0d miscompares=%0d", vectors, fails);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fe_capture_multi.md
FE_CAPTURE_MULTI -- requirements
Module: fe_capture_multi

Interface
REQ-001 SHALL have parameter pCHANNELS, default 4, number of event channels (1..16).
REQ-002 SHALL have parameter pTIMESTAMP_FULL_WIDTH, default 16, width of the delta-time counter and record time field.
REQ-003 SHALL have parameter pCAPTURE_LEN_WIDTH, default 24, width of the capture-length limit and counter.
REQ-004 SHALL use one clock and an asynchronous, active-low reset; ports: fe_clk  in  1  sole clock; reset_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: I_event  in  pCHANNELS  per-channel single-cycle event strobe; I_data_cmd  in  2*pCHANNELS  per-channel 2-bit command (channel c at bits 2c+1:2c).
REQ-006 SHALL have ports: I_arm  in  1  arm pulse; I_capture_enable  in  1  capture gate; I_target_trig  in  1  trigger; I_capture_while_trig  in  1  trigger-window mode; I_capture_len  in  pCAPTURE_LEN_WIDTH  DATA-record limit (0 = unlimited); I_max_short_timestamp  in  pTIMESTAMP_FULL_WIDTH  short-delta limit; I_fifo_full  in  1  downstream FIFO full.
REQ-007 SHALL have ports: O_fifo_wr  out  1  write strobe; O_fifo_command  out  2  record command; O_fifo_chan  out  clog2(pCHANNELS) (min 1)  source channel; O_fifo_time  out  pTIMESTAMP_FULL_WIDTH  delta time; O_capturing  out  1  state is CAPTURE; O_capture_done  out  1  state is DONE; O_overflow  out  1  sticky FIFO-full stop flag.

Function
REQ-008 SHALL implement FSM IDLE, ARMED, CAPTURE, DONE; I_arm in any state -> ARMED next cycle, clearing pending flags, delta counter, capture counter and O_overflow.
REQ-009 SHALL move ARMED -> CAPTURE when I_capture_enable=1 and (I_capture_while_trig ? I_target_trig : 1).
REQ-010 SHALL move CAPTURE -> DONE on first of: capture count reaches nonzero I_capture_len; I_capture_enable=0; I_capture_while_trig=1 and I_target_trig=0; I_fifo_full=1 (also sets O_overflow).
REQ-011 SHALL, only in CAPTURE, set channel c pending and latch its command when I_event[c]=1; if the flag is already set and not granted that cycle, the event is dropped; if set and granted the same cycle, the new event stays pending.
REQ-012 SHALL grant at most one pending channel per cycle, round-robin starting at the channel after the last granted one (channel 0 first after arm).
REQ-013 SHALL issue at most one registered write per cycle; I_event at edge t yields O_fifo_wr at edge t+2 earliest.
REQ-014 SHALL emit DATA record (O_fifo_command = channel's latched command, O_fifo_chan = channel, O_fifo_time = delta counter) and clear that pending flag when granted delta <= I_max_short_timestamp.
REQ-015 SHALL, when granted delta > I_max_short_timestamp, emit TIME record (command FE_FIFO_CMD_TIME, time = delta, chan = 0) instead, leaving the event pending for the next cycle.
REQ-016 SHALL, with no pending event and delta = all-ones minus 1, emit a saturation TIME record with time = delta.
REQ-017 SHALL hold delta at 0 in IDLE/ARMED/DONE, increment by 1 per CAPTURE cycle, load 1 after any write, never wrap.
REQ-018 SHALL count DATA records only in the capture counter; TIME records are not counted.
REQ-019 SHALL never assert O_fifo_wr while I_fifo_full=1 or outside CAPTURE.

Reset
REQ-020 SHALL, on reset_n=0, asynchronously force state IDLE and all outputs, pending flags and counters to 0, including mid-capture.
REQ-021 SHALL resume operation on the first fe_clk edge after reset_n deasserts, requiring I_arm to capture.

Configuration
REQ-022 SHALL, with macro FE_CAPTURE_MULTI_STATS_EN defined, add output O_dropped_events (out, 16) counting dropped events (REQ-011), saturating at 0xFFFF, cleared by arm and reset.
REQ-023 SHALL, without FE_CAPTURE_MULTI_STATS_EN, omit O_dropped_events and its counter entirely; all other behaviour identical.

Verification
REQ-024 SHALL cover: pCHANNELS=4, arm, enable, I_event=4'b0101 one cycle, max_short=8 -> DATA ch0 then DATA ch2 on consecutive cycles, times 2 and 1.
REQ-025 SHALL cover: single event on ch1 after 20 idle cycles, max_short=8 -> TIME record time=21, then DATA ch1 time=1.
REQ-026 SHALL cover: no events for 65535 CAPTURE cycles (width 16) -> TIME record time=0xFFFE, delta restarts at 1.
REQ-027 SHALL cover: I_capture_len=3, continuous events on ch3 -> exactly 3 DATA records, then O_capture_done=1.
REQ-028 SHALL cover: I_fifo_full=1 mid-capture -> no further writes, O_overflow=1, DONE; with STATS_EN, back-to-back I_event[0] for 2 cycles while ch1 pending wins -> O_dropped_events=1.
REQ-029 SHALL cover: reset_n pulsed low mid-capture between edges -> all outputs 0 immediately, state IDLE.
